// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg: shared types and constants for the MEM-stage load/store unit
package mem_stage_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP,
        DONE
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Access width from funct3; unlisted encodings fall back to a full word
    function automatic logic [1:0] f3_size(input logic [2:0] f3);
        return (f3[1:0] == F3_B[1:0]) ? SZ_B :
               (f3[1:0] == F3_H[1:0]) ? SZ_H : SZ_W;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// mem_stage_lsu_align: store lane steering, byte strobes, load extraction and misalignment check
import mem_stage_lsu_pkg::*;

module mem_stage_lsu_align #(
    parameter int XLEN = 32
) (
    input  logic            i_access_req,
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_store_data,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_wdata,
    output logic [3:0]      o_wstrb,
    output logic [XLEN-1:0] o_load_ext,
    output logic            o_misaligned
);

    logic [1:0]  w_size;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sx;

    // Lane steering for stores and extraction/extension for loads
    always_comb begin
        w_size       = f3_size(i_funct3);
        w_byte       = i_rdata[{i_addr_lo, 3'b000} +: 8];
        w_half       = i_addr_lo[1] ? i_rdata[16 +: 16] : i_rdata[0 +: 16];
        w_sx         = ~i_funct3[2];
        o_misaligned = i_access_req &
                       (((i_funct3[1:0] == 2'b01) & i_addr_lo[0]) |
                        ((i_funct3[1:0] == 2'b10) & (i_addr_lo != 2'b00)));
        o_wdata      = (w_size == SZ_B) ? {(XLEN/8){i_store_data[7:0]}} :
                       (w_size == SZ_H) ? {(XLEN/16){i_store_data[15:0]}} : i_store_data;
        o_wstrb      = (w_size == SZ_B) ? (4'b0001 << i_addr_lo) :
                       (w_size == SZ_H) ? (i_addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        o_load_ext   = (w_size == SZ_B) ? {{(XLEN-8){w_sx & w_byte[7]}}, w_byte} :
                       (w_size == SZ_H) ? {{(XLEN-16){w_sx & w_half[15]}}, w_half} : i_rdata;
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit issuing one valid/ready request per access
import mem_stage_lsu_pkg::*;

module mem_stage_lsu #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_mem_read,
    input  logic            i_mem_write,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_store_data,
    input  logic            i_pipe_advance,
    output logic            o_dmem_req_valid,
    input  logic            i_dmem_req_ready,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [XLEN-1:0] o_dmem_wdata,
    output logic [3:0]      o_dmem_wstrb,
    input  logic            i_dmem_rsp_valid,
    input  logic [XLEN-1:0] i_dmem_rsp_rdata,
    output logic [XLEN-1:0] o_load_data,
    output logic            o_mem_stall,
    output logic            o_misaligned
);

    lsu_state_t      r_state;
    lsu_state_t      w_next;
    lsu_state_t      w_after_req;
    logic [XLEN-1:0] r_load_q;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_load_ext;
    logic [3:0]      w_wstrb;
    logic            w_misaligned;
    logic            w_access;
    logic            w_req_valid;
    logic            w_we;

    mem_stage_lsu_align #(.XLEN(XLEN)) u_align (
        .i_access_req (i_mem_read | i_mem_write),
        .i_funct3     (i_funct3),
        .i_addr_lo    (i_addr[1:0]),
        .i_store_data (i_store_data),
        .i_rdata      (i_dmem_rsp_rdata),
        .o_wdata      (w_wdata),
        .o_wstrb      (w_wstrb),
        .o_load_ext   (w_load_ext),
        .o_misaligned (w_misaligned)
    );

    assign w_access    = (i_mem_read | i_mem_write) & ~w_misaligned;
    assign o_load_data = r_load_q;

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Load result capture, only while a response is being awaited
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)                                   r_load_q <= '0;
        else if (r_state == RSP && i_dmem_rsp_valid)   r_load_q <= w_load_ext;
    end

    // Next state; DONE holds until the pipeline advances so a held instruction is not re-issued
    always_comb begin
        w_after_req = i_mem_read ? RSP : DONE;
        w_next      = (r_state == IDLE) ? (w_access ? (i_dmem_req_ready ? w_after_req : REQ) : IDLE) :
                      (r_state == REQ)  ? (i_dmem_req_ready ? w_after_req : REQ) :
                      (r_state == RSP)  ? (i_dmem_rsp_valid ? DONE : RSP) :
                                          (i_pipe_advance ? IDLE : DONE);
    end

    // Bus and stall outputs; request fields are zero whenever no request is offered
    always_comb begin
        w_req_valid      = (r_state == IDLE && w_access) || r_state == REQ;
        w_we             = w_req_valid & ~i_mem_read;
        o_dmem_req_valid = w_req_valid;
        o_dmem_we        = w_we;
        o_dmem_addr      = w_req_valid ? {i_addr[XLEN-1:2], 2'b00} : '0;
        o_dmem_wdata     = w_we ? w_wdata : '0;
        o_dmem_wstrb     = w_we ? w_wstrb : 4'b0000;
        o_mem_stall      = w_req_valid || r_state == RSP;
        o_misaligned     = w_misaligned;
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed table-driven bench for the MEM-stage load/store unit
import mem_stage_lsu_pkg::*;

module tb_mem_stage_lsu;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        logic        mis;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
        logic [31:0] e_load;
    } vec_t;

    localparam int NV = 19;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        pipe_advance = 1'b0;
    logic        dmem_req_ready = 1'b0;
    logic        dmem_rsp_valid = 1'b0;
    logic [31:0] dmem_rsp_rdata = 32'h0;
    logic        dmem_req_valid;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] load_data;
    logic        mem_stall;
    logic        misaligned;

    int   n_vec = 0;
    int   n_bad = 0;
    int   n_req = 0;
    int   req_base;
    logic [31:0] last_load = 32'h0;
    vec_t tbl [NV];

    always #5 clk = ~clk;

    always @(posedge clk) if (dmem_req_valid && dmem_req_ready) n_req <= n_req + 1;

    mem_stage_lsu #(.XLEN(32)) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_mem_read       (mem_read),
        .i_mem_write      (mem_write),
        .i_funct3         (funct3),
        .i_addr           (addr),
        .i_store_data     (store_data),
        .i_pipe_advance   (pipe_advance),
        .o_dmem_req_valid (dmem_req_valid),
        .i_dmem_req_ready (dmem_req_ready),
        .o_dmem_we        (dmem_we),
        .o_dmem_addr      (dmem_addr),
        .o_dmem_wdata     (dmem_wdata),
        .o_dmem_wstrb     (dmem_wstrb),
        .i_dmem_rsp_valid (dmem_rsp_valid),
        .i_dmem_rsp_rdata (dmem_rsp_rdata),
        .o_load_data      (load_data),
        .o_mem_stall      (mem_stall),
        .o_misaligned     (misaligned)
    );

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %08h, want %08h", name, id, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        addr       = a;
        store_data = sd;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        set_in(v.rd, v.wr, v.f3, v.addr, v.sd);
        dmem_req_ready = 1'b1;
        #2;
        chk("mis", id, 32'(misaligned), 32'(v.mis));
        if (v.mis) begin
            chk("mis_req", id, 32'(dmem_req_valid), 32'd0);
            chk("mis_stall", id, 32'(mem_stall), 32'd0);
            tick;
        end else begin
            chk("req_valid", id, 32'(dmem_req_valid), 32'd1);
            chk("req_stall", id, 32'(mem_stall), 32'd1);
            chk("we", id, 32'(dmem_we), 32'(v.wr));
            chk("addr", id, dmem_addr, v.e_addr);
            if (v.wr) begin
                chk("wdata", id, dmem_wdata, v.e_wdata);
                chk("wstrb", id, 32'(dmem_wstrb), 32'(v.e_wstrb));
            end
            tick;
            dmem_req_ready = 1'b0;
            if (v.rd) begin
                #1;
                chk("rsp_stall", id, 32'(mem_stall), 32'd1);
                chk("rsp_req", id, 32'(dmem_req_valid), 32'd0);
                dmem_rsp_valid = 1'b1;
                dmem_rsp_rdata = v.rdata;
                tick;
                dmem_rsp_valid = 1'b0;
                dmem_rsp_rdata = 32'h0;
                last_load = v.e_load;
                chk("load_data", id, load_data, v.e_load);
            end
            chk("done_stall", id, 32'(mem_stall), 32'd0);
            chk("done_req", id, 32'(dmem_req_valid), 32'd0);
            pipe_advance = 1'b1;
            tick;
            pipe_advance = 1'b0;
        end
        set_in(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, F3_W,  32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF};
        tbl[1]  = '{1'b1, 1'b0, F3_B,  32'h103, 32'h0, 32'h80FF0000, 1'b0, 32'h100, 32'h0, 4'h0, 32'hFFFFFF80};
        tbl[2]  = '{1'b1, 1'b0, F3_BU, 32'h103, 32'h0, 32'h80FF0000, 1'b0, 32'h100, 32'h0, 4'h0, 32'h00000080};
        tbl[3]  = '{1'b1, 1'b0, F3_H,  32'h102, 32'h0, 32'h80FF0000, 1'b0, 32'h100, 32'h0, 4'h0, 32'hFFFF80FF};
        tbl[4]  = '{1'b1, 1'b0, F3_HU, 32'h102, 32'h0, 32'h80FF0000, 1'b0, 32'h100, 32'h0, 4'h0, 32'h000080FF};
        tbl[5]  = '{1'b1, 1'b0, F3_B,  32'h101, 32'h0, 32'h12345678, 1'b0, 32'h100, 32'h0, 4'h0, 32'h00000056};
        tbl[6]  = '{1'b1, 1'b0, F3_H,  32'h100, 32'h0, 32'h1234F678, 1'b0, 32'h100, 32'h0, 4'h0, 32'hFFFFF678};
        tbl[7]  = '{1'b1, 1'b0, 3'b011, 32'h104, 32'h0, 32'h11223344, 1'b0, 32'h104, 32'h0, 4'h0, 32'h11223344};
        tbl[8]  = '{1'b1, 1'b0, F3_BU, 32'h100, 32'h0, 32'h000000FF, 1'b0, 32'h100, 32'h0, 4'h0, 32'h000000FF};
        tbl[9]  = '{1'b1, 1'b0, F3_B,  32'h102, 32'h0, 32'h00800000, 1'b0, 32'h100, 32'h0, 4'h0, 32'hFFFFFF80};
        tbl[10] = '{1'b0, 1'b1, F3_W,  32'h300, 32'hCAFEF00D, 32'h0, 1'b0, 32'h300, 32'hCAFEF00D, 4'hF, 32'h0};
        tbl[11] = '{1'b0, 1'b1, F3_B,  32'h101, 32'h000000A5, 32'h0, 1'b0, 32'h100, 32'hA5A5A5A5, 4'h2, 32'h0};
        tbl[12] = '{1'b0, 1'b1, F3_H,  32'h202, 32'h1234ABCD, 32'h0, 1'b0, 32'h200, 32'hABCDABCD, 4'hC, 32'h0};
        tbl[13] = '{1'b0, 1'b1, F3_B,  32'h103, 32'h11223344, 32'h0, 1'b0, 32'h100, 32'h44444444, 4'h8, 32'h0};
        tbl[14] = '{1'b0, 1'b1, F3_H,  32'h200, 32'h0000BEEF, 32'h0, 1'b0, 32'h200, 32'hBEEFBEEF, 4'h3, 32'h0};
        tbl[15] = '{1'b1, 1'b0, F3_W,  32'h101, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0};
        tbl[16] = '{1'b1, 1'b0, F3_H,  32'h103, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0};
        tbl[17] = '{1'b0, 1'b1, F3_W,  32'h102, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0};
        tbl[18] = '{1'b0, 1'b1, F3_H,  32'h101, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0};

        repeat (3) tick;
        reset = 1'b0;
        tick;
        chk("rst_req", 0, 32'(dmem_req_valid), 32'd0);
        chk("rst_we", 0, 32'(dmem_we), 32'd0);
        chk("rst_addr", 0, dmem_addr, 32'h0);
        chk("rst_wdata", 0, dmem_wdata, 32'h0);
        chk("rst_wstrb", 0, 32'(dmem_wstrb), 32'd0);
        chk("rst_stall", 0, 32'(mem_stall), 32'd0);
        chk("rst_mis", 0, 32'(misaligned), 32'd0);
        chk("rst_load", 0, load_data, 32'h0);

        for (int i = 0; i < NV; i++) run_vec(tbl[i], i);

        // Store held off by ready=0 for three cycles, with a stray response that must be ignored
        req_base = n_req;
        set_in(1'b0, 1'b1, F3_H, 32'h206, 32'h1234ABCD);
        for (int i = 0; i < 4; i++) begin
            dmem_req_ready = (i == 3);
            dmem_rsp_valid = (i == 1);
            dmem_rsp_rdata = 32'hFFFFFFFF;
            #2;
            chk("sh_req", i, 32'(dmem_req_valid), 32'd1);
            chk("sh_addr", i, dmem_addr, 32'h204);
            chk("sh_wdata", i, dmem_wdata, 32'hABCDABCD);
            chk("sh_wstrb", i, 32'(dmem_wstrb), 32'hC);
            chk("sh_stall", i, 32'(mem_stall), 32'd1);
            tick;
        end
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        chk("sh_done_stall", 0, 32'(mem_stall), 32'd0);
        chk("sh_load_kept", 0, load_data, last_load);
        chk("sh_nreq", 0, n_req - req_base, 32'd1);
        pipe_advance = 1'b1;
        tick;
        pipe_advance = 1'b0;

        // Load completes while the pipeline is held elsewhere: DONE must not re-issue
        req_base = n_req;
        set_in(1'b1, 1'b0, F3_W, 32'h108, 32'h0);
        dmem_req_ready = 1'b1;
        tick;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'h55AA00FF;
        tick;
        dmem_rsp_valid = 1'b0;
        dmem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("hold_stall", i, 32'(mem_stall), 32'd0);
            chk("hold_req", i, 32'(dmem_req_valid), 32'd0);
            chk("hold_load", i, load_data, 32'h55AA00FF);
            tick;
        end
        chk("hold_nreq", 0, n_req - req_base, 32'd1);
        dmem_req_ready = 1'b0;
        pipe_advance = 1'b1;
        tick;
        pipe_advance = 1'b0;
        run_vec('{1'b1, 1'b0, F3_W, 32'h10C, 32'h0, 32'h01020304, 1'b0, 32'h10C, 32'h0, 4'h0, 32'h01020304}, 100);
        run_vec('{1'b1, 1'b0, F3_HU, 32'h112, 32'h0, 32'hBEEF0000, 1'b0, 32'h110, 32'h0, 4'h0, 32'h0000BEEF}, 101);
        chk("b2b_nreq", 0, n_req - req_base, 32'd3);

        // Reset while waiting for a response; the late response must be dropped
        set_in(1'b1, 1'b0, F3_W, 32'h120, 32'h0);
        dmem_req_ready = 1'b1;
        tick;
        dmem_req_ready = 1'b0;
        chk("pre_rst_stall", 0, 32'(mem_stall), 32'd1);
        #2;
        reset = 1'b1;
        set_in(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        chk("mid_rst_stall", 0, 32'(mem_stall), 32'd0);
        chk("mid_rst_load", 0, load_data, 32'h0);
        chk("mid_rst_req", 0, 32'(dmem_req_valid), 32'd0);
        tick;
        reset = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'h12345678;
        tick;
        dmem_rsp_valid = 1'b0;
        chk("post_rst_load", 0, load_data, 32'h0);
        chk("post_rst_stall", 0, 32'(mem_stall), 32'd0);
        run_vec('{1'b0, 1'b1, F3_W, 32'h400, 32'h0BADF00D, 32'h0, 1'b0, 32'h400, 32'h0BADF00D, 4'hF, 32'h0}, 200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit for the MEM stage of the RV32I pipeline. It is the consumer of the EX/MEM pipeline register.
- Takes the memory-access fields from that register and issues one request per instruction on a valid/ready data-memory bus. It then waits for load data, aligns and sign/zero-extends it, and presents it to the MEM/WB register.
- Raises mem_stall to freeze the upstream pipeline while an access is outstanding.

Parameters:
- XLEN, 32, data and address width.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- mem_read  in  1  EX/MEM: instruction is a load
- mem_write  in  1  EX/MEM: instruction is a store
- funct3  in  3  EX/MEM: size/sign (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010)
- addr  in  XLEN  EX/MEM: ALU-computed byte address
- store_data  in  XLEN  EX/MEM: rs2 value
- pipe_advance  in  1  high when the EX/MEM register loads new contents this cycle
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_we  out  1  1 = store
- dmem_addr  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00})
- dmem_wdata  out  XLEN  lane-replicated store data
- dmem_wstrb  out  4  byte-lane enables
- dmem_rsp_valid  in  1  load data valid
- dmem_rsp_rdata  in  XLEN  raw word read
- load_data  out  XLEN  aligned/extended load result for MEM/WB
- mem_stall  out  1  freeze IF/ID/EX/MEM registers
- misaligned  out  1  access not naturally aligned; no request issued

Behaviour:
- FSM states: IDLE, REQ, RSP, DONE. All outputs are combinational from state plus inputs, except load_data, which comes from a register load_q.
- Reset (async): state=IDLE, load_q=0. With no access present, all outputs are 0.
- access = (mem_read | mem_write) & ~misaligned.
- misaligned = (mem_read|mem_write) & ((funct3[1:0]==01 & addr[0]) | (funct3[1:0]==10 & addr[1:0]!=0)). Combinational.
  - Misaligned accesses never stall and never issue a request.
- IDLE:
  - if access: dmem_req_valid=1, mem_stall=1.
  - On dmem_req_ready the next state is RSP for a load, DONE for a store. Otherwise REQ.
- REQ: dmem_req_valid=1, mem_stall=1. Same exits as IDLE on dmem_req_ready.
- RSP:
  - dmem_req_valid=0, mem_stall=1.
  - On dmem_rsp_valid, load_q <= extracted/extended data, then go to DONE.
- DONE:
  - mem_stall=0, dmem_req_valid=0.
  - If pipe_advance, go to IDLE; else stay in DONE. This prevents re-issue while the pipeline is held by another hazard.
- Request fields are held stable while dmem_req_valid=1 and ready=0; the stall guarantees stable inputs.
- Store lanes:
  - SB: wdata={4{sd[7:0]}}, wstrb=1<<addr[1:0].
  - SH: wdata={2{sd[15:0]}}, wstrb=addr[1]?1100:0011.
  - SW: wdata=sd, wstrb=1111.
- Load extraction: byte/half selected by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- load_data = load_q.
- Ignored inputs:
  - dmem_rsp_valid outside RSP.
  - dmem_req_ready when dmem_req_valid=0.
  - funct3 values not listed: treated as LW/SW width.
- Latency (ready=1, rsp one cycle later): the load shows mem_stall for 2 cycles and load_data is valid in cycle 2 (DONE). A store stalls for 1 cycle.
- Reset mid-operation returns to IDLE immediately. An in-flight response after reset is ignored.

Decomposition:
- pipeline_pkg gains:
  - lsu_state_t enum (IDLE, REQ, RSP, DONE).
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
- One combinational sub-module, lsu_align, contains the store lane steering, wstrb generation, load extraction/extension and misaligned detection. The FSM stays in mem_stage_lsu.

Test Plan:
- LW addr=0x100, ready=1, rsp next cycle with rdata=0xDEADBEEF -> req_valid 1 cycle, dmem_addr=0x100; stall 2 cycles; load_data=0xDEADBEEF in DONE.
- LB addr=0x103, rdata=0x80FF_0000 -> load_data=0xFFFFFF80. LBU at the same address -> 0x00000080. LH addr=0x102 -> 0xFFFF80FF.
- SH addr=0x206, sd=0x1234ABCD, ready held low 3 cycles -> req_valid/addr=0x204/wdata=0xABCDABCD/wstrb=1100 stable for 4 cycles; stall 4 cycles; no rsp expected.
- LW addr=0x101 -> misaligned=1, req_valid=0, stall=0. SB addr=0x101 -> misaligned=0, wstrb=0010.
- Load completes while pipe_advance=0 for 3 cycles -> FSM stays in DONE, exactly one request issued, load_data stable; after pipe_advance, back-to-back loads each issue one request.
- Assert reset while in RSP, then pulse rsp_valid -> state IDLE, load_data=0, stall=0, response ignored.
